mult_share_arbiter: RTL and testbench

Round-robin scheduler that shares one pipelined 6x6 unsigned multiplier among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier. A tag pipeline tracks ownership through the multiplier latency, and each product is returned to a per-requester response slot.

---
 rtl/mult_share_arbiter_pkg.sv | 28 ++
 rtl/mult_share_arbiter_rr_arbiter.sv | 37 +++
 rtl/mult_share_arbiter.sv | 145 ++++++++++++++
 tb/tb_mult_share_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared definitions for the multiplier-sharing scheduler.
//   DEF_*       : default widths, latency and requester count
//   TAG_ID_W    : width of the owner id carried through the tag pipeline (up to 8 requesters)
//   tag_t       : {valid, id} ownership tag that travels alongside the multiplier pipeline
//   popcount8   : number of set bits in an 8-bit vector, used for the in-flight count
package mult_share_arbiter_pkg;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_W       = 6;
  localparam int DEF_PW      = 12;
  localparam int DEF_MUL_LAT = 3;
  localparam int TAG_ID_W    = 3;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req         : request vector, one bit per requester
//   ptr         : index that has highest priority this cycle
//   grant       : one-hot grant, all zero when nothing requests
//   grant_idx   : index of the granted requester (0 when none)
//   grant_valid : some requester was granted
module mult_share_arbiter_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  // Walk the requesters in priority order ptr, ptr+1, ... (wrapping) and
  // stop at the first one asserting req. The inner loop matches the
  // rotated position against a constant index so no variable bit select
  // is needed, which keeps the logic valid for any N_REQ, not just powers of two.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int off = 0; off < N_REQ; off++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!grant_valid && req[i] && ((int'(ptr) + off) % N_REQ == i)) begin
          grant[i]    = 1'b1;
          grant_idx   = ID_W'(i);
          grant_valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler sharing one pipelined W x W unsigned multiplier
// among N_REQ requesters.
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : requester i has an operand pair on req_a/req_b slice i
//   req_a/b    : packed operands, slice i belongs to requester i
//   req_ready  : one-hot combinational grant
//   mul_a/b    : registered operands to the external multiplier
//   mul_p      : product, MUL_LAT edges after the operands
//   rsp_valid  : response slot i holds a product
//   rsp_data   : packed slot products, slice i belongs to requester i
//   rsp_ready  : requester i consumes slot i
//   inflight   : number of requesters with an outstanding request
//
// Handshake: a transfer happens at a posedge where valid and ready are both
// high. On the request side ready is combinational and may depend on valid;
// the requester holds valid and operands stable until the transfer. On the
// response side the slot's valid stays high, with data stable, until the
// requester's ready is sampled high.
module mult_share_arbiter
  import mult_share_arbiter_pkg::*;
#(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int W       = DEF_W,
  parameter int PW      = DEF_PW,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [W-1:0]       mul_a,
  output logic [W-1:0]       mul_b,
  input  logic [PW-1:0]      mul_p,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [N_REQ*PW-1:0] rsp_data,
  input  logic [N_REQ-1:0]   rsp_ready,
  output logic [3:0]         inflight
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] grant;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] busy_next;
  logic [N_REQ-1:0] consume;
  logic [N_REQ-1:0] cap_hit;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_valid;
  logic [W-1:0]     sel_a;
  logic [W-1:0]     sel_b;
  tag_t             tag_pipe [MUL_LAT+1];
  logic [PW-1:0]    slot     [N_REQ];

  // A requester with a result still waiting in its slot (or in flight)
  // is not eligible, so each slot has at most one owner transaction.
  assign elig      = req_valid & ~busy;
  assign req_ready = grant;
  assign consume   = rsp_valid & rsp_ready;
  assign busy_next = (busy | grant) & ~consume;

  mult_share_arbiter_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req         (elig),
    .ptr         (ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // One-hot operand mux; yields zero when there is no grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*W +: W];
        sel_b = req_b[i*W +: W];
      end
    end
  end

  // The last tag stage lines up with mul_p; decode it into a per-slot strobe.
  always_comb begin
    cap_hit = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cap_hit[i] = tag_pipe[MUL_LAT].valid && (tag_pipe[MUL_LAT].id == TAG_ID_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a     <= '0;
      mul_b     <= '0;
      busy      <= '0;
      rsp_valid <= '0;
      ptr       <= '0;
      inflight  <= '0;
      for (int k = 0; k <= MUL_LAT; k++) begin
        tag_pipe[k] <= '0;
      end
      for (int i = 0; i < N_REQ; i++) begin
        slot[i] <= '0;
      end
    end else begin
      mul_a             <= sel_a;
      mul_b             <= sel_b;
      tag_pipe[0].valid <= grant_valid;
      tag_pipe[0].id    <= grant_valid ? TAG_ID_W'(grant_idx) : '0;
      for (int k = 1; k <= MUL_LAT; k++) begin
        tag_pipe[k] <= tag_pipe[k-1];
      end
      busy     <= busy_next;
      // Registered from busy_next so inflight always equals popcount(busy).
      inflight <= popcount8(8'(busy_next));
      if (grant_valid) begin
        ptr <= (grant_idx == ID_W'(N_REQ-1)) ? '0 : grant_idx + 1'b1;
      end
      // Capture and consume never target the same slot: the slot being
      // captured is still busy, so it cannot already hold a valid result.
      for (int i = 0; i < N_REQ; i++) begin
        if (cap_hit[i]) begin
          rsp_valid[i] <= 1'b1;
          slot[i]      <= mul_p;
        end else if (consume[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rsp_data
    assign rsp_data[gi*PW +: PW] = slot[gi];
  end

  // A capture into an occupied slot would silently lose a product.
  a_no_overwrite : assert property (@(posedge clk) disable iff (rst)
    (cap_hit & rsp_valid) == '0);

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;
  import mult_share_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = DEF_W;
  localparam int PW  = DEF_PW;
  localparam int LAT = DEF_MUL_LAT;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*W-1:0]  req_a;
  logic [N*W-1:0]  req_b;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    mul_a;
  logic [W-1:0]    mul_b;
  logic [PW-1:0]   mul_p;
  logic [N-1:0]    rsp_valid;
  logic [N*PW-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic [3:0]      inflight;

  mult_share_arbiter #(.N_REQ(N), .W(W), .PW(PW), .MUL_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .inflight  (inflight)
  );

  // ---------------- clock / reset / multiplier model ----------------
  always #5 clk = ~clk;

  logic [PW-1:0] p_pipe [LAT] = '{default: '0};
  always @(posedge clk) begin
    p_pipe[0] <= PW'(mul_a) * PW'(mul_b);
    for (int k = 1; k < LAT; k++) p_pipe[k] <= p_pipe[k-1];
  end
  assign mul_p = p_pipe[LAT-1];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int errors = 0;

  // Products in acceptance order; results must leave the pipeline in this order.
  logic [PW-1:0] exp_q[$];

  int            ptr_m;
  bit            busy_m [N];
  bit            rv_m   [N];
  logic [PW-1:0] rd_m   [N];
  int            cnt_m  [N];
  logic [PW-1:0] prod_m [N];
  logic [N-1:0]  prev_rv;
  logic [N-1:0]  last_rdy;
  int            last_grant;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < N; i++) begin
      busy_m[i] = 0; rv_m[i] = 0; rd_m[i] = '0; cnt_m[i] = 0; prod_m[i] = '0;
    end
    exp_q.delete();
    prev_rv = '0;
  endtask

  // First valid, non-busy requester found scanning upward from ptr_m with wrap.
  function automatic logic [N-1:0] pick(input logic [N-1:0] v);
    logic [N-1:0] r;
    int idx;
    r = '0;
    for (int o = 0; o < N; o++) begin
      idx = (ptr_m + o) % N;
      if (r == '0 && v[idx] && !busy_m[idx]) r[idx] = 1'b1;
    end
    return r;
  endfunction

  // One clock cycle: check the grant mid-cycle, advance the model at the
  // edge, then check every registered output shortly after the edge.
  task automatic tick();
    logic [N-1:0] exp_rdy;
    logic [N-1:0] cons;
    logic [N-1:0] rv_vec;
    logic [W-1:0] ea, eb;
    int g, nb;
    @(negedge clk);
    exp_rdy  = pick(req_valid);
    last_rdy = req_ready;
    check("req_ready", req_ready, exp_rdy);
    for (int i = 0; i < N; i++) cons[i] = rv_m[i] & rsp_ready[i];
    g = -1;
    for (int i = 0; i < N; i++) if (exp_rdy[i]) g = i;
    ea = '0; eb = '0;
    if (g >= 0) begin
      ea = req_a[g*W +: W];
      eb = req_b[g*W +: W];
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
      ea = '0; eb = '0; g = -1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_m[i] > 0) begin
          cnt_m[i]--;
          if (cnt_m[i] == 0) begin rv_m[i] = 1; rd_m[i] = prod_m[i]; end
        end
      end
      for (int i = 0; i < N; i++) if (cons[i]) begin rv_m[i] = 0; busy_m[i] = 0; end
      if (g >= 0) begin
        busy_m[g] = 1;
        cnt_m[g]  = LAT + 1;
        prod_m[g] = PW'(ea) * PW'(eb);
        exp_q.push_back(prod_m[g]);
        ptr_m = (g + 1) % N;
      end
    end
    last_grant = g;
    #1;
    check("mul_a", mul_a, ea);
    check("mul_b", mul_b, eb);
    nb = 0;
    for (int i = 0; i < N; i++) begin
      rv_vec[i] = rv_m[i];
      nb += busy_m[i] ? 1 : 0;
      check("rsp_data", rsp_data[i*PW +: PW], rd_m[i]);
    end
    check("rsp_valid", rsp_valid, rv_vec);
    check("inflight", inflight, nb);
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i] && !prev_rv[i]) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL return_order: slot %0d rose with no pending request", i);
        end else begin
          check("return_order", rsp_data[i*PW +: PW], exp_q.pop_front());
        end
      end
    end
    prev_rv = rsp_valid;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = 1'b1;
    req_a[i*W +: W]  = a;
    req_b[i*W +: W]  = b;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  vec_t vecs [7];

  // ---------------- test sequence ----------------
  initial begin
    logic [PW-1:0] bp [4];
    logic [N-1:0]  prev_gnt;
    int n1, n_other, n_fair;

    vecs[0] = '{a: 6'd5,  b: 6'd7,  p: 12'd35};
    vecs[1] = '{a: 6'd0,  b: 6'd0,  p: 12'd0};
    vecs[2] = '{a: 6'd63, b: 6'd1,  p: 12'd63};
    vecs[3] = '{a: 6'd63, b: 6'd63, p: 12'd3969};
    vecs[4] = '{a: 6'd1,  b: 6'd2,  p: 12'd2};
    vecs[5] = '{a: 6'd3,  b: 6'd4,  p: 12'd12};
    vecs[6] = '{a: 6'd0,  b: 6'd63, p: 12'd0};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    model_reset();
    last_grant = -1;
    last_rdy = '0;
    @(posedge clk); @(posedge clk); #1;
    check("reset_mul_a", mul_a, 0);
    check("reset_mul_b", mul_b, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_inflight", inflight, 0);
    check("reset_rsp_data", rsp_data[31:0], 0);
    rst = 1'b0;

    // Single requests with fixed operands and expected products.
    for (int k = 0; k < 7; k++) begin
      int i;
      i = k % N;
      set_req(i, vecs[k].a, vecs[k].b);
      tick();
      check("single_grant", last_rdy, 32'(1) << i);
      clr_req(i);
      check("single_mul_a", mul_a, vecs[k].a);
      check("single_mul_b", mul_b, vecs[k].b);
      repeat (LAT) tick();
      check("single_not_early", rsp_valid[i], 0);
      tick();
      check("single_rsp_valid", rsp_valid[i], 1);
      check("single_rsp_data", rsp_data[i*PW +: PW], vecs[k].p);
      check("single_inflight", inflight, 1);
      rsp_ready[i] = 1'b1;
      tick();
      rsp_ready[i] = 1'b0;
      check("single_released", rsp_valid[i], 0);
      check("single_inflight_zero", inflight, 0);
      check("single_data_hold", rsp_data[i*PW +: PW], vecs[k].p);
    end

    // Burst: four requesters at once, back-to-back grants and returns.
    do_reset();
    rsp_ready = '1;
    bp[0] = 12'd2; bp[1] = 12'd12; bp[2] = 12'd3969; bp[3] = 12'd0;
    set_req(0, 6'd1, 6'd2);
    set_req(1, 6'd3, 6'd4);
    set_req(2, 6'd63, 6'd63);
    set_req(3, 6'd0, 6'd63);
    for (int t = 0; t < N; t++) begin
      tick();
      check("burst_grant", last_rdy, 32'(1) << t);
      clr_req(t);
    end
    check("burst_peak_inflight", inflight, 4);
    for (int t = 0; t < N; t++) begin
      tick();
      check("burst_rsp_valid", rsp_valid, 32'(1) << t);
      check("burst_rsp_data", rsp_data[t*PW +: PW], bp[t]);
    end
    repeat (2) tick();

    // Backpressure on slot 1 while others keep flowing.
    do_reset();
    rsp_ready = 4'b1101;
    set_req(0, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    set_req(1, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    set_req(2, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
    n1 = 0; n_other = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (last_rdy[i]) begin
          if (i == 1) n1++; else n_other++;
          set_req(i, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
        end
      end
    end
    check("bp_req1_single_grant", n1, 1);
    check("bp_others_progress", (n_other >= 4) ? 1 : 0, 1);
    rsp_ready[1] = 1'b1;
    tick();
    check("bp_no_regrant_on_consume", last_rdy[1], 0);
    repeat (4) tick();
    req_valid = '0;
    repeat (6) tick();

    // Fairness: two requesters always valid must alternate.
    do_reset();
    rsp_ready = '1;
    set_req(0, 6'd9, 6'd9);
    set_req(2, 6'd10, 6'd11);
    prev_gnt = 4'b0100;
    n_fair = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (last_rdy != '0) begin
        check("fair_alternate", last_rdy, (prev_gnt == 4'b0001) ? 4'b0100 : 4'b0001);
        prev_gnt = last_rdy;
        n_fair++;
      end
    end
    check("fair_grant_count", (n_fair >= 8) ? 1 : 0, 1);
    req_valid = '0;
    repeat (6) tick();

    // Reset while two requests are in flight.
    do_reset();
    rsp_ready = '1;
    set_req(1, 6'd7, 6'd9);
    set_req(3, 6'd5, 6'd5);
    tick();
    check("mid_grant1", last_rdy, 4'b0010);
    clr_req(1);
    tick();
    check("mid_grant3", last_rdy, 4'b1000);
    clr_req(3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      check("mid_no_rsp", rsp_valid, 0);
      check("mid_inflight", inflight, 0);
    end
    set_req(3, 6'd2, 6'd2);
    set_req(2, 6'd3, 6'd3);
    tick();
    check("mid_first_grant_lowest", last_rdy, 4'b0100);
    req_valid = '0;
    repeat (8) tick();

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rsp_ready = 4'($urandom_range(0, 15));
      rst = ($urandom_range(0, 99) == 0);
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i*W +: W] = 6'($urandom_range(0, 63));
          req_b[i*W +: W] = 6'($urandom_range(0, 63));
        end
      end
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
